// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC generator: redirect-source and FSM encodings.
package pc_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      PC_SEL_NONE   = 2'b00,
      PC_SEL_BRANCH = 2'b01,
      PC_SEL_JUMP   = 2'b10,
      PC_SEL_TRAP   = 2'b11
   } pc_sel_e;

   typedef enum logic [1:0] {
      ST_BOOT = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_e;

   function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC candidate select: sequential PC+4, branch, jump or trap target.
module pc_next_mux
   import pc_pkg::*;
(
   input  logic [XLEN-1:0] pc_plus4,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jump_target,
   input  logic [XLEN-1:0] trap_target,
   input  pc_sel_e         sel,
   output logic [XLEN-1:0] next_pc
);

   always_comb begin
      next_pc = pc_plus4;
      case (sel)
         PC_SEL_NONE:   next_pc = pc_plus4;
         PC_SEL_BRANCH: next_pc = branch_target;
         PC_SEL_JUMP:   next_pc = jump_target;
         PC_SEL_TRAP:   next_pc = trap_target;
         default:       next_pc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: BOOT/RUN/HALT control, PC register with redirects,
// misaligned-target trapping and an accepted-fetch counter.
module pc_gen
   import pc_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  pc_sel,
   input  logic        redirect_valid,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   input  logic [31:0] trap_vector,
   input  logic        stall,
   input  logic        req_ready,
   output logic        req_valid,
   output logic [31:0] req_addr,
   output logic        misalign_err,
   output logic [31:0] misalign_addr,
   output logic [31:0] fetch_count
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            misalign_err_q, misalign_err_d;
   logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
   logic [XLEN-1:0] fetch_count_q, fetch_count_d;

   pc_sel_e         sel;
   pc_sel_e         mux_sel;
   logic            redirect;
   logic            accepted;
   logic [XLEN-1:0] trap_target;
   logic [XLEN-1:0] next_pc;

   assign sel         = pc_sel_e'(pc_sel);
   assign redirect    = redirect_valid && (sel != PC_SEL_NONE);
   assign req_valid   = (state_q == ST_RUN);
   assign accepted    = req_valid && req_ready;
   assign trap_target = trap_vector & 32'hFFFF_FFFC;
   assign mux_sel     = redirect ? sel : PC_SEL_NONE;

   pc_next_mux u_next_mux (
      .pc_plus4      (pc_q + 32'd4),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .trap_target   (trap_target),
      .sel           (mux_sel),
      .next_pc       (next_pc)
   );

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      misalign_err_d  = 1'b0;
      misalign_addr_d = misalign_addr_q;
      fetch_count_d   = fetch_count_q;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (accepted) fetch_count_d = fetch_count_q + 32'd1;
            // A redirect wins over both stall and a pending handshake.
            if (redirect) begin
               if (sel == PC_SEL_TRAP) begin
                  pc_d = next_pc;
               end else if (is_misaligned(next_pc)) begin
                  misalign_err_d  = 1'b1;
                  misalign_addr_d = next_pc;
                  state_d         = ST_HALT;
               end else begin
                  pc_d = next_pc;
               end
            end else if (accepted && !stall) begin
               pc_d = next_pc;
            end
         end
         ST_HALT: begin
            if (redirect && (sel == PC_SEL_TRAP)) begin
               pc_d    = next_pc;
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_BOOT;
         pc_q            <= RESET_VECTOR;
         misalign_err_q  <= 1'b0;
         misalign_addr_q <= '0;
         fetch_count_q   <= '0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         misalign_err_q  <= misalign_err_d;
         misalign_addr_q <= misalign_addr_d;
         fetch_count_q   <= fetch_count_d;
      end
   end

   assign req_addr      = pc_q;
   assign misalign_err  = misalign_err_q;
   assign misalign_addr = misalign_addr_q;
   assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: expected fetches and misalign events are queued
// by the stimulus and checked by independent monitors on the falling edge.
module tb_pc_gen;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] cnt;
   } fetch_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [1:0]  pc_sel = 2'b00;
   logic        redirect_valid = 1'b0;
   logic [31:0] branch_target = '0;
   logic [31:0] jump_target = '0;
   logic [31:0] trap_vector = '0;
   logic        stall = 1'b0;
   logic        req_ready = 1'b0;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        misalign_err;
   logic [31:0] misalign_addr;
   logic [31:0] fetch_count;

   int vectors = 0;
   int miscompares = 0;
   fetch_t      fetch_q[$];
   logic [31:0] mis_q[$];

   pc_gen #(.RESET_VECTOR(32'h0000_0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pc_sel         (pc_sel),
      .redirect_valid (redirect_valid),
      .branch_target  (branch_target),
      .jump_target    (jump_target),
      .trap_vector    (trap_vector),
      .stall          (stall),
      .req_ready      (req_ready),
      .req_valid      (req_valid),
      .req_addr       (req_addr),
      .misalign_err   (misalign_err),
      .misalign_addr  (misalign_addr),
      .fetch_count    (fetch_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_fetch(input logic [31:0] a, input logic [31:0] c);
      fetch_t f;
      f.addr = a;
      f.cnt  = c;
      fetch_q.push_back(f);
   endtask

   task automatic redir(input logic [1:0] s, input logic [31:0] tgt);
      redirect_valid = 1'b1;
      pc_sel         = s;
      branch_target  = tgt;
      jump_target    = tgt;
      trap_vector    = tgt;
   endtask

   task automatic no_redir();
      redirect_valid = 1'b0;
      pc_sel         = 2'b00;
   endtask

   // Fetch monitor: every handshake must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && req_valid && req_ready) begin
         if (fetch_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_fetch: got addr 0x%08h expected none", req_addr);
         end else begin
            fetch_t f;
            f = fetch_q.pop_front();
            check("fetch_addr", req_addr, f.addr);
            check("fetch_count", fetch_count, f.cnt);
         end
      end
   end

   // Misalign monitor: each pulse must correspond to one queued event.
   always @(negedge clk) begin
      if (rst_n && misalign_err) begin
         if (mis_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_misalign: got 0x%08h expected none", misalign_addr);
         end else begin
            logic [31:0] m;
            m = mis_q.pop_front();
            check("misalign_addr", misalign_addr, m);
            check("misalign_valid_low", {31'd0, req_valid}, 32'd0);
         end
      end
   end

   initial begin
      #2 rst_n = 1'b0;
      step();
      step();
      check("rst_req_valid", {31'd0, req_valid}, 32'd0);
      check("rst_req_addr", req_addr, 32'h0);
      check("rst_fetch_count", fetch_count, 32'd0);
      check("rst_misalign_err", {31'd0, misalign_err}, 32'd0);
      check("rst_misalign_addr", misalign_addr, 32'd0);

      rst_n = 1'b1;
      check("boot_valid_low", {31'd0, req_valid}, 32'd0);
      step();
      check("run_valid_high", {31'd0, req_valid}, 32'd1);

      // Sequential fetch from the reset vector
      req_ready = 1'b1;
      expect_fetch(32'h0, 0);  step();
      expect_fetch(32'h4, 1);  step();
      expect_fetch(32'h8, 2);  step();
      expect_fetch(32'hC, 3);  step();
      check("count_after_seq", fetch_count, 32'd4);

      // Back-pressure at 0x10
      req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold_addr", req_addr, 32'h10);
         check("hold_count", fetch_count, 32'd4);
      end
      req_ready = 1'b1;
      expect_fetch(32'h10, 4); step();
      expect_fetch(32'h14, 5); step();
      expect_fetch(32'h18, 6); step();
      expect_fetch(32'h1C, 7); step();

      // Stall plus branch redirect: redirect wins, acceptance still counted
      stall = 1'b1;
      redir(2'b01, 32'h100);
      expect_fetch(32'h20, 8); step();
      no_redir();
      // Stall alone re-requests the same address
      expect_fetch(32'h100, 9);  step();
      stall = 1'b0;
      expect_fetch(32'h100, 10); step();
      // pc_sel == 00 with redirect_valid is ignored
      redir(2'b00, 32'h500);
      expect_fetch(32'h104, 11); step();
      no_redir();
      // Redirect abandons an unaccepted request
      req_ready = 1'b0;
      redir(2'b10, 32'h200);
      step();
      no_redir();
      req_ready = 1'b1;

      // Misaligned jump -> HALT
      redir(2'b10, 32'h102);
      expect_fetch(32'h200, 12);
      mis_q.push_back(32'h102);
      step();
      check("halt_valid_low", {31'd0, req_valid}, 32'd0);
      check("halt_pc_kept", req_addr, 32'h200);
      // Branch and stall ignored in HALT
      stall = 1'b1;
      redir(2'b01, 32'h300);
      step();
      stall = 1'b0;
      check("halt_ignores_branch", {31'd0, req_valid}, 32'd0);
      check("misalign_held", misalign_addr, 32'h102);
      // Trap exits HALT with low bits cleared
      redir(2'b11, 32'h203);
      step();
      no_redir();
      check("trap_run", {31'd0, req_valid}, 32'd1);
      expect_fetch(32'h200, 13); step();

      // Wrap at top of address space
      req_ready = 1'b0;
      redir(2'b11, 32'hFFFF_FFFE);
      step();
      no_redir();
      req_ready = 1'b1;
      expect_fetch(32'hFFFF_FFFC, 14); step();
      expect_fetch(32'h0, 15);         step();

      // Asynchronous reset during a pending request at 0x40
      req_ready = 1'b0;
      redir(2'b10, 32'h40);
      step();
      no_redir();
      check("pre_reset_addr", req_addr, 32'h40);
      req_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("async_valid_drop", {31'd0, req_valid}, 32'd0);
      check("async_count_clear", fetch_count, 32'd0);
      check("async_pc_reset", req_addr, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      expect_fetch(32'h0, 0); step();
      expect_fetch(32'h4, 1); step();
      req_ready = 1'b0;
      step();

      check("fetch_queue_drained", fetch_q.size(), 32'd0);
      check("misalign_queue_drained", mis_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Guard against a hung run
   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter: RESET_VECTOR, default 32'h0000_0000, first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: pc_sel  input  2  redirect source: 00 none, 01 branch, 10 jump, 11 trap.
REQ-005 Port: redirect_valid  input  1  qualifies pc_sel for one cycle.
REQ-006 Port: branch_target, jump_target, trap_vector  input  32 each  candidate next PCs.
REQ-007 Port: stall  input  1  hazard hold from decode; blocks sequential advance only.
REQ-008 Port: req_ready  input  1  instruction memory accepts request.
REQ-009 Port: req_valid  output  1  fetch request valid.
REQ-010 Port: req_addr  output  32  fetch address (current PC).
REQ-011 Port: misalign_err  output  1  one-cycle pulse on misaligned redirect target.
REQ-012 Port: misalign_addr  output  32  offending target, held until next misalign event.
REQ-013 Port: fetch_count  output  32  number of accepted fetch requests.

Function
REQ-014 States SHALL be BOOT, RUN, HALT; BOOT->RUN unconditionally after one cycle.
REQ-015 In BOOT and HALT req_valid SHALL be 0; in RUN req_valid SHALL be 1.
REQ-016 Handshake: request accepted when req_valid && req_ready in the same cycle.
REQ-017 Without redirect, req_addr SHALL hold stable until accepted.
REQ-018 Accepted && !stall && no redirect: PC <= PC + 4 next cycle, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 Accepted && stall: PC SHALL hold; the same address is re-requested.
REQ-020 redirect_valid with pc_sel != 00 SHALL override stall and handshake; PC <= selected target next cycle; an unaccepted request at the old address is abandoned.
REQ-021 redirect_valid with pc_sel == 00 SHALL be ignored.
REQ-022 Branch/jump target with [1:0] != 0: PC unchanged, misalign_err = 1 for one cycle, misalign_addr <= target, state -> HALT.
REQ-023 Trap redirect SHALL force trap_vector[1:0] to 0, never flags misalign, and is the only exit from HALT (HALT -> RUN, PC <= trap target).
REQ-024 In HALT, branch/jump redirects and stall SHALL be ignored.
REQ-025 Redirect in the same cycle as an acceptance: acceptance counted in fetch_count, PC takes redirect target (not PC+4).
REQ-026 fetch_count SHALL increment by 1 per acceptance, wrapping at 2^32.
REQ-027 Redirect in BOOT SHALL be ignored.

Reset
REQ-028 On rst_n low, asynchronously: state = BOOT, PC = RESET_VECTOR, req_valid = 0, misalign_err = 0, misalign_addr = 0, fetch_count = 0.
REQ-029 Reset mid-request SHALL drop req_valid immediately; no acceptance counted in that cycle.
REQ-030 Deassertion SHALL be sampled at rising edge; first request presents RESET_VECTOR in the second cycle after deassertion.

Structure
REQ-031 Shared package pc_pkg SHALL hold PC_SEL_NONE/BRANCH/JUMP/TRAP encodings, state encodings, and XLEN = 32.
REQ-032 Next-PC selection SHALL be a sub-module pc_next_mux: 32-bit 4:1 select of {PC+4, branch, jump, trap} by pc_sel; state, PC register, counter and error logic remain in pc_gen.

Verification
REQ-033 Reset release, req_ready = 1, no stall -> req_addr 0x0, 0x4, 0x8 on consecutive cycles; fetch_count = 3 after third acceptance.
REQ-034 req_ready = 0 for 3 cycles at PC 0x10 -> req_addr holds 0x10, fetch_count unchanged; ready = 1 -> next 0x14.
REQ-035 stall = 1 at PC 0x20 with branch redirect to 0x100 same cycle -> next req_addr 0x100.
REQ-036 Jump redirect to 0x0000_0102 -> misalign_err pulse 1 cycle, misalign_addr = 0x102, req_valid = 0; trap to 0x0000_0203 -> req_addr 0x200, RUN.
REQ-037 PC 0xFFFF_FFFC accepted -> next req_addr 0x0000_0000.
REQ-038 rst_n low while req_valid = 1 at 0x40 -> req_valid 0 same cycle, fetch_count 0, restart at RESET_VECTOR.
